ub_row_loader: RTL and testbench

Reads one systolic-array row at a time from the Unified Buffer's byte-wide read port. It assembles `SA_LENGTH` consecutive bytes into a full row vector and hands each row downstream over a valid/ready handshake. It sits directly downstream of the Unified Buffer and upstream of the systolic-array input skew/feeder. The controller issues `num_rows` rows starting at `base_addr`, spaced `stride` bytes apart.

---
 rtl/ub_pkg.sv | 22 ++
 rtl/ub_row_loader_if.sv | 23 ++
 rtl/ub_row_addr_gen.sv | 63 ++++++
 rtl/ub_row_loader.sv | 151 +++++++++++++++
 tb/tb_ub_row_loader.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ub_pkg.sv
// Shared Unified Buffer types: row-loader state enum, byte width,
// and the byte-address width helper used by the UB integration.
package ub_pkg;

    localparam int UB_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DONE
    } row_loader_state_t;

    function automatic int ub_addr_width(
        input int addr_width,
        input int no_banks,
        input int sa_length
    );
        return addr_width + $clog2(no_banks) + $clog2(sa_length);
    endfunction

endpackage

// File: rtl/ub_row_loader_if.sv
// Row handshake bundle between the row loader (master) and the
// systolic-array feeder (slave).
interface ub_row_loader_if
    import ub_pkg::*;
#(
    parameter int SA_LENGTH = 256
);
    logic [UB_BYTE_W*SA_LENGTH-1:0] row_data;
    logic                           row_valid;
    logic                           row_ready;

    modport master (
        output row_data,
        output row_valid,
        input  row_ready
    );

    modport slave (
        input  row_data,
        input  row_valid,
        output row_ready
    );
endinterface

// File: rtl/ub_row_addr_gen.sv
// Row-base accumulator, byte counter and registered UB read address
// for ub_row_loader.
module ub_row_addr_gen #(
    parameter int AW = 17,
    parameter int CW = 9
) (
    input  logic          CLK,
    input  logic          ASYNC_RST,
    input  logic          en,
    input  logic          srst,
    input  logic          load,
    input  logic          step,
    input  logic          next_row,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride,
    input  logic [CW-1:0] len,
    output logic [AW-1:0] rdaddr,
    output logic [CW-1:0] cnt,
    output logic          issue_ok
);

    logic [AW-1:0] row_base;
    logic [AW-1:0] stride_q;
    logic [AW-1:0] base_nxt;
    logic [CW-1:0] cnt_nxt;

    assign base_nxt = row_base + stride_q;
    assign cnt_nxt  = cnt + CW'(1);
    assign issue_ok = cnt < len;

    // rdaddr only advances to addresses that will really be issued,
    // so it holds the last issued address once a row is fetched.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            row_base <= '0;
            stride_q <= '0;
            cnt      <= '0;
            rdaddr   <= '0;
        end else if (en) begin
            if (srst) begin
                row_base <= '0;
                stride_q <= '0;
                cnt      <= '0;
                rdaddr   <= '0;
            end else if (load) begin
                row_base <= base;
                stride_q <= stride;
                cnt      <= '0;
                rdaddr   <= base;
            end else if (next_row) begin
                row_base <= base_nxt;
                cnt      <= '0;
                rdaddr   <= base_nxt;
            end else if (step) begin
                cnt <= cnt_nxt;
                if (cnt_nxt < len) begin
                    rdaddr <= row_base + AW'(cnt_nxt);
                end
            end
        end
    end

endmodule

// File: rtl/ub_row_loader.sv
// Assembles SA_LENGTH-byte rows from the UB byte read port.
// Optional ROW_LOADER_PARTIAL_ROW_EN adds a per-command row_len.
module ub_row_loader
    import ub_pkg::*;
#(
    parameter  int SA_LENGTH  = 256,
    parameter  int ADDR_WIDTH = 10,
    parameter  int NO_BANKS   = 8,
    localparam int AddrWidth  =
        ub_addr_width(ADDR_WIDTH, NO_BANKS, SA_LENGTH)
) (
    input  logic                 CLK,
    input  logic                 ASYNC_RST,
    input  logic                 SYNC_RST,
    input  logic                 EN,
    input  logic                 start,
    input  logic [AddrWidth-1:0] base_addr,
    input  logic [AddrWidth-1:0] stride,
    input  logic [15:0]          num_rows,
`ifdef ROW_LOADER_PARTIAL_ROW_EN
    input  logic [$clog2(SA_LENGTH):0] row_len,
`endif
    output logic [AddrWidth-1:0] ub_rdaddr,
    input  logic [UB_BYTE_W-1:0] ub_rddata,
    ub_row_loader_if.master      row_if,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(SA_LENGTH) + 1;

    row_loader_state_t state, nxt;

    logic [15:0]                    rows_q;
    logic [15:0]                    row_idx;
    logic [CW-1:0]                  len_in;
    logic [CW-1:0]                  len_q;
    logic [CW-1:0]                  cnt;
    logic [CW-1:0]                  tag_lane;
    logic                           tag_v;
    logic                           issue_ok;
    logic [UB_BYTE_W*SA_LENGTH-1:0] row_q;

    logic accept, xfer, last_row, step, fetch_done;

    assign accept     = (state == IDLE) && start;
    assign xfer       = (state == HOLD) && row_if.row_ready;
    assign last_row   = row_idx == (rows_q - 16'd1);
    assign step       = (state == FETCH) && issue_ok;
    assign fetch_done = tag_v && (tag_lane == len_q - CW'(1));

`ifdef ROW_LOADER_PARTIAL_ROW_EN
    assign len_in = (row_len > CW'(SA_LENGTH)) ? CW'(SA_LENGTH) : row_len;
`else
    assign len_in = CW'(SA_LENGTH);
    assign len_q  = CW'(SA_LENGTH);
`endif

    ub_row_addr_gen #(.AW(AddrWidth), .CW(CW)) u_addr_gen (
        .CLK      (CLK),
        .ASYNC_RST(ASYNC_RST),
        .en       (EN),
        .srst     (SYNC_RST),
        .load     (accept && (num_rows != 16'd0)),
        .step     (step),
        .next_row (xfer && !last_row),
        .base     (base_addr),
        .stride   (stride),
        .len      (len_in),
        .rdaddr   (ub_rdaddr),
        .cnt      (cnt),
        .issue_ok (issue_ok)
    );

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state <= IDLE;
        end else if (EN) begin
            state <= SYNC_RST ? IDLE : nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (start) begin
                if (num_rows == 16'd0)    nxt = DONE;
                else if (len_in == '0)    nxt = HOLD;
                else                      nxt = FETCH;
            end
            FETCH: if (fetch_done) nxt = HOLD;
            HOLD: if (row_if.row_ready) begin
                if (last_row)             nxt = DONE;
                else if (len_q == '0)     nxt = HOLD;
                else                      nxt = FETCH;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // The read tag follows each issued address by one cycle, matching
    // UB read latency; it freezes with EN just like the UB output.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            rows_q   <= '0;
            row_idx  <= '0;
            tag_v    <= 1'b0;
            tag_lane <= '0;
            row_q    <= '0;
`ifdef ROW_LOADER_PARTIAL_ROW_EN
            len_q    <= '0;
`endif
        end else if (EN) begin
            if (SYNC_RST) begin
                rows_q   <= '0;
                row_idx  <= '0;
                tag_v    <= 1'b0;
                tag_lane <= '0;
                row_q    <= '0;
`ifdef ROW_LOADER_PARTIAL_ROW_EN
                len_q    <= '0;
`endif
            end else begin
                tag_v    <= step;
                tag_lane <= cnt;
                if (accept) begin
                    rows_q  <= num_rows;
                    row_idx <= '0;
`ifdef ROW_LOADER_PARTIAL_ROW_EN
                    len_q   <= len_in;
                    row_q   <= '0;
`endif
                end else if (xfer) begin
                    row_idx <= row_idx + 16'd1;
                end
                for (int j = 0; j < SA_LENGTH; j++) begin
                    if (tag_v && (tag_lane == CW'(j))) begin
                        row_q[UB_BYTE_W*j +: UB_BYTE_W] <= ub_rddata;
                    end
                end
            end
        end
    end

    assign row_if.row_data  = row_q;
    assign row_if.row_valid = (state == HOLD);
    assign busy             = (state != IDLE);
    assign done             = (state == DONE);

endmodule

// File: tb/tb_ub_row_loader.sv
// Directed bench for ub_row_loader: SA_LENGTH=4, 7-bit byte address,
// UB model returns address[7:0] one cycle after the address.
module tb_ub_row_loader;

    localparam int SA = 4;
    localparam int AW = 7;

    logic          CLK = 1'b0;
    logic          ASYNC_RST, SYNC_RST, EN, start;
    logic [AW-1:0] base_addr, stride, ub_rdaddr;
    logic [15:0]   num_rows;
    logic [7:0]    ub_rddata;
    logic          busy, done;
`ifdef ROW_LOADER_PARTIAL_ROW_EN
    logic [2:0]    row_len;
`endif

    ub_row_loader_if #(.SA_LENGTH(SA)) row_if ();

    ub_row_loader #(.SA_LENGTH(SA), .ADDR_WIDTH(4), .NO_BANKS(2)) dut (
        .CLK      (CLK),
        .ASYNC_RST(ASYNC_RST),
        .SYNC_RST (SYNC_RST),
        .EN       (EN),
        .start    (start),
        .base_addr(base_addr),
        .stride   (stride),
        .num_rows (num_rows),
`ifdef ROW_LOADER_PARTIAL_ROW_EN
        .row_len  (row_len),
`endif
        .ub_rdaddr(ub_rdaddr),
        .ub_rddata(ub_rddata),
        .row_if   (row_if.master),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST)  ub_rddata <= 8'h00;
        else if (EN)     ub_rddata <= 8'(ub_rdaddr);
    end

    typedef struct {
        string         name;
        logic [AW-1:0] base;
        logic [AW-1:0] stride;
        int            rows;
        logic [31:0]   r0;
        logic [31:0]   r1;
        int            done_cyc;
    } vec_t;

    vec_t vt[5];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Leaves start high at the negedge of cycle 0.
    task automatic start_cmd(input logic [AW-1:0] b, input logic [AW-1:0] s,
                             input int r);
        @(negedge CLK);
        base_addr = b;
        stride    = s;
        num_rows  = 16'(r);
        start     = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int            nrow, done_cyc, first_v;
        logic [AW-1:0] ea;
        row_if.row_ready = 1'b1;
        start_cmd(v.base, v.stride, v.rows);
        nrow = 0; done_cyc = -1; first_v = -1;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            @(negedge CLK);
            start = 1'b0;
            if (cyc <= SA) begin
                ea = v.base + AW'(cyc - 1);
                chk({v.name, " addr"}, 32'(ub_rdaddr), 32'(ea));
            end
            if (row_if.row_valid) begin
                if (first_v < 0) first_v = cyc;
                chk({v.name, " row"}, row_if.row_data,
                    (nrow == 0) ? v.r0 : v.r1);
                nrow++;
            end
            if (done) begin
                done_cyc = cyc;
                ea = v.base + AW'((v.rows - 1) * int'(v.stride)) + AW'(SA - 1);
                chk({v.name, " addr hold"}, 32'(ub_rdaddr), 32'(ea));
            end
        end
        chk({v.name, " done cycle"}, 32'(done_cyc), 32'(v.done_cyc));
        chk({v.name, " rows seen"}, 32'(nrow), 32'(v.rows));
        chk({v.name, " first valid"}, 32'(first_v), 32'(SA + 2));
    endtask

    task automatic wait_valid(input string nm, input int budget,
                              output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            start = 1'b0;
            if (row_if.row_valid) ok = 1'b1;
        end
        if (!ok) chk({nm, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge CLK);
    endtask

    initial begin
        logic          ok;
        logic [AW-1:0] prev;
        int            dones, done_cyc;

        vt[0] = '{"single", 7'h10, 7'h04, 1, 32'h13121110, 32'h0, 7};
        vt[1] = '{"two rows", 7'h00, 7'h08, 2, 32'h03020100,
                  32'h0B0A0908, 13};
        vt[2] = '{"wrap", 7'h7E, 7'h01, 1, 32'h01007F7E, 32'h0, 7};
        vt[3] = '{"stride wrap", 7'h7C, 7'h04, 2, 32'h7F7E7D7C,
                  32'h03020100, 13};
        vt[4] = '{"stride 0", 7'h20, 7'h00, 2, 32'h23222120,
                  32'h23222120, 13};

        ASYNC_RST = 1'b0; SYNC_RST = 1'b0; EN = 1'b1; start = 1'b0;
        base_addr = '0; stride = '0; num_rows = '0;
        row_if.row_ready = 1'b1;
`ifdef ROW_LOADER_PARTIAL_ROW_EN
        row_len = 3'd4;
`endif
        repeat (2) @(negedge CLK);
        chk("reset ub_rdaddr", 32'(ub_rdaddr), 32'h0);
        chk("reset row_data", row_if.row_data, 32'h0);
        chk("reset row_valid", 32'(row_if.row_valid), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        ASYNC_RST = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        // Backpressure: first row held stable for 5 stalled cycles.
        row_if.row_ready = 1'b0;
        start_cmd(7'h00, 7'h08, 2);
        wait_valid("bp row0", 20, ok);
        for (int i = 0; i < 5; i++) begin
            chk("bp valid held", 32'(row_if.row_valid), 32'h1);
            chk("bp data held", row_if.row_data, 32'h03020100);
            @(negedge CLK);
        end
        row_if.row_ready = 1'b1;
        chk("bp valid at accept", 32'(row_if.row_valid), 32'h1);
        dones = 0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (row_if.row_valid && !ok) begin
                chk("bp row1", row_if.row_data, 32'h0B0A0908);
                ok = 1'b1;
            end
            if (done) dones++;
        end
        chk("bp row1 seen", 32'(ok), 32'h1);
        chk("bp done count", 32'(dones), 32'd1);
        chk("bp busy after", 32'(busy), 32'h0);

        // Zero rows: done in cycle 1, read address untouched.
        prev = ub_rdaddr;
        start_cmd(7'h55, 7'h01, 0);
        @(negedge CLK);
        start = 1'b0;
        chk("zero done c1", 32'(done), 32'h1);
        chk("zero busy c1", 32'(busy), 32'h1);
        chk("zero no read", 32'(ub_rdaddr), 32'(prev));
        @(negedge CLK);
        chk("zero done c2", 32'(done), 32'h0);
        chk("zero busy c2", 32'(busy), 32'h0);

        // Second start during FETCH is ignored.
        start_cmd(7'h40, 7'h04, 1);
        done_cyc = -1;
        for (int cyc = 1; cyc <= 30 && done_cyc < 0; cyc++) begin
            @(negedge CLK);
            start = (cyc == 2);
            if (cyc == 2) base_addr = 7'h50;
            if (cyc <= SA)
                chk("ign addr", 32'(ub_rdaddr), 32'(7'h40 + AW'(cyc - 1)));
            if (row_if.row_valid)
                chk("ign row", row_if.row_data, 32'h43424140);
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        chk("ign done cycle", 32'(done_cyc), 32'd7);
        @(negedge CLK);

        // Async reset during FETCH.
        start_cmd(7'h10, 7'h04, 1);
        repeat (3) begin
            @(negedge CLK);
            start = 1'b0;
        end
        ASYNC_RST = 1'b0;
        #1;
        chk("arst busy", 32'(busy), 32'h0);
        chk("arst ub_rdaddr", 32'(ub_rdaddr), 32'h0);
        chk("arst row_data", row_if.row_data, 32'h0);
        chk("arst row_valid", 32'(row_if.row_valid), 32'h0);
        @(negedge CLK);
        ASYNC_RST = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (done) dones++;
        end
        chk("arst no done", 32'(dones), 32'd0);
        run_vec(vt[0]);

        // Synchronous reset during FETCH.
        start_cmd(7'h10, 7'h04, 1);
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        SYNC_RST = 1'b1;
        @(negedge CLK);
        SYNC_RST = 1'b0;
        chk("srst busy", 32'(busy), 32'h0);
        chk("srst ub_rdaddr", 32'(ub_rdaddr), 32'h0);
        chk("srst row_data", row_if.row_data, 32'h0);

        // EN low for cycles 2..4 shifts the run by three cycles.
        start_cmd(7'h30, 7'h04, 1);
        done_cyc = -1;
        for (int cyc = 1; cyc <= 30 && done_cyc < 0; cyc++) begin
            @(negedge CLK);
            start = 1'b0;
            if (cyc == 2) EN = 1'b0;
            if (cyc == 5) EN = 1'b1;
            if (cyc == 3 || cyc == 4)
                chk("stall addr frozen", 32'(ub_rdaddr), 32'h31);
            if (row_if.row_valid)
                chk("stall row", row_if.row_data, 32'h33323130);
            if (done) done_cyc = cyc;
        end
        chk("stall done cycle", 32'(done_cyc), 32'd10);
        @(negedge CLK);

`ifdef ROW_LOADER_PARTIAL_ROW_EN
        row_len = 3'd2;
        start_cmd(7'h20, 7'h04, 1);
        wait_valid("partial 2", 20, ok);
        chk("partial 2 row", row_if.row_data, 32'h00002120);
        wait_idle(10);
        row_len = 3'd0;
        start_cmd(7'h20, 7'h04, 1);
        wait_valid("partial 0", 20, ok);
        chk("partial 0 row", row_if.row_data, 32'h00000000);
        wait_idle(10);
        row_len = 3'd7;
        start_cmd(7'h20, 7'h04, 1);
        wait_valid("partial sat", 20, ok);
        chk("partial sat row", row_if.row_data, 32'h23222120);
        wait_idle(10);
        row_len = 3'd4;
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
